time_set_ctrl: RTL and testbench
================================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter DB_CNT, default 500_000: clock cycles a key must be stable before a press is accepted.
REQ-002 clk  input  1  system clock; all logic is in this single clock domain.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 key_mode  input  1  raw mode key, active-low.
REQ-005 key_sel  input  1  raw field-select key, active-low.
REQ-006 key_inc  input  1  raw increment key, active-low.
REQ-007 time_num  input  24  current BCD time {h1,h0,m1,m0,s1,s0} from the time counter.
REQ-008 data_num  input  24  current BCD date {y1,y0,mo1,mo0,d1,d0} from the time counter.
REQ-009 model  output  2  mode: 00 show time, 01 show date, 11 adjust; 10 is never driven.
REQ-010 date_time_ch  output  1  0 = time, 1 = date.
REQ-011 adjust_time_num  output  24  edited BCD time.
REQ-012 adjust_date_num  output  24  edited BCD date.
REQ-013 blink_mask  output  6  per-digit blink enable, bit 5 = leftmost digit.

Function
REQ-014 Each key SHALL pass through its own debouncer, which emits a one-cycle press pulse when the input has been low and stable for DB_CNT consecutive cycles; the press is emitted once per press and re-arms only after the key is stable high for DB_CNT cycles.
REQ-015 The FSM SHALL have four states, each with fixed outputs:
  - RUN_T: model=00, ch=0
  - RUN_D: model=01, ch=1
  - ADJ_T: model=11, ch=0
  - ADJ_D: model=11, ch=1
REQ-016 A mode pulse SHALL advance the state RUN_T->RUN_D->ADJ_T->ADJ_D->RUN_T, taking effect on the next clock edge.
REQ-017 On the RUN_D->ADJ_T transition edge, adjust_time_num SHALL load time_num; on the ADJ_T->ADJ_D transition edge, adjust_date_num SHALL load data_num.
REQ-018 The field index SHALL be 2 (hour/year), 1 (min/month) or 0 (sec/day), and SHALL be set to 2 on entering any ADJ state.
REQ-019 In an ADJ state, a sel pulse SHALL move the field 2->1->0->2.
REQ-020 In an ADJ state, an inc pulse SHALL increment the selected two-digit BCD field by 1 with wrap, per these ranges:
  - hour 00-23
  - min and sec 00-59
  - year 00-99
  - month 01-12
  - day 01..max, where max = 31 for months 01,03,05,07,08,10,12; 30 for 04,06,09,11; 28 for 02
REQ-021 If a month increment makes the current day exceed the new month's max, the day SHALL be clamped to that max in the same cycle.
REQ-022 sel and inc pulses in RUN states SHALL be ignored.
REQ-023 Simultaneous pulses: mode takes priority over sel, and sel over inc; lower-priority pulses in that cycle are discarded.
REQ-024 An ADJ state whose edited value holds an invalid BCD digit SHALL still operate: an inc on that field writes the range minimum.
REQ-025 blink_mask SHALL be 000000 in RUN states; in ADJ states it SHALL be 110000, 001100 or 000011 for field 2, 1 or 0.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 While rst_n is low, the block SHALL hold:
  - state RUN_T, model=00, date_time_ch=0
  - adjust_time_num=24'h000000, adjust_date_num=24'h000101
  - field=2, blink_mask=000000
  - all debouncer counters cleared, no pulse pending
REQ-028 A reset asserted mid-adjust SHALL discard all edits; after release, no press pulse SHALL be emitted until a fresh full debounce completes.

Structure
REQ-029 A shared package SHALL hold:
  - model encodings (MODEL_TIME=00, MODEL_DATE=01, MODEL_ADJ=11)
  - FSM state encodings
  - field range constants
  - the month-length table
REQ-030 Sub-module key_debounce (parameter DB_CNT; ports clk, rst_n, key_in, press) SHALL be instantiated three times; the rest is flat.

Verification (DB_CNT=4)
REQ-031 Hold key_inc low 2 cycles, then high; repeat with key_mode low 10 cycles -> no pulse from the 2-cycle glitch; exactly one state advance for the 10-cycle press.
REQ-032 time_num=24'h235649, three mode presses -> model=11, ch=0, adjust_time_num=24'h235649, blink_mask=110000.
REQ-033 In ADJ_T at field 2 with hour 23, one inc -> adjust_time_num=24'h005649; then sel, sel, and inc at sec 59 -> sec=00, with no carry into minutes.
REQ-034 In ADJ_D with data_num=24'h200131, sel then inc -> month 02 and day clamped, adjust_date_num=24'h200228; with month 12, one inc -> month 01.
REQ-035 mode and inc pulses asserted in the same cycle in ADJ_T -> state becomes ADJ_D and the time value is unchanged.
REQ-036 rst_n pulsed low while in ADJ_D -> next cycle shows model=00, adjust_date_num=24'h000101, blink_mask=000000.

Source files
------------

// File: rtl/time_set_ctrl_pkg.sv
// rtl/time_set_ctrl_pkg.sv - shared encodings, field ranges and BCD helpers for time_set_ctrl
package time_set_ctrl_pkg;

  localparam logic [1:0] MODEL_TIME = 2'b00;
  localparam logic [1:0] MODEL_DATE = 2'b01;
  localparam logic [1:0] MODEL_ADJ  = 2'b11;

  typedef enum logic [1:0] {
    RUN_T = 2'd0,
    RUN_D = 2'd1,
    ADJ_T = 2'd2,
    ADJ_D = 2'd3
  } state_t;

  localparam logic [1:0] FIELD_HI  = 2'd2;
  localparam logic [1:0] FIELD_MID = 2'd1;
  localparam logic [1:0] FIELD_LO  = 2'd0;

  localparam logic [7:0] HOUR_MIN  = 8'd0;
  localparam logic [7:0] HOUR_MAX  = 8'd23;
  localparam logic [7:0] MS_MIN    = 8'd0;
  localparam logic [7:0] MS_MAX    = 8'd59;
  localparam logic [7:0] YEAR_MIN  = 8'd0;
  localparam logic [7:0] YEAR_MAX  = 8'd99;
  localparam logic [7:0] MONTH_MIN = 8'd1;
  localparam logic [7:0] MONTH_MAX = 8'd12;
  localparam logic [7:0] DAY_MIN   = 8'd1;

  localparam logic [23:0] TIME_RST = 24'h000000;
  localparam logic [23:0] DATE_RST = 24'h000101;

  localparam logic [7:0] MONTH_DAYS [1:12] = '{
    8'd31, 8'd28, 8'd31, 8'd30, 8'd31, 8'd30,
    8'd31, 8'd31, 8'd30, 8'd31, 8'd30, 8'd31
  };

  function automatic logic bcd_valid(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] bcd2bin(input logic [7:0] v);
    return {4'd0, v[7:4]} * 8'd10 + {4'd0, v[3:0]};
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [7:0] b);
    return (b / 8'd10) * 8'd16 + (b % 8'd10);
  endfunction

  // Anything not a valid in-range BCD value restarts the field at its minimum.
  function automatic logic [7:0] field_inc(input logic [7:0] v, input logic [7:0] lo,
                                           input logic [7:0] hi);
    logic [7:0] b;
    b = bcd2bin(v);
    if (!bcd_valid(v) || b < lo || b >= hi) return bin2bcd(lo);
    return bin2bcd(b + 8'd1);
  endfunction

  function automatic logic [7:0] month_days(input logic [7:0] mo);
    logic [7:0] b;
    b = bcd2bin(mo);
    if (bcd_valid(mo) && b >= MONTH_MIN && b <= MONTH_MAX) return MONTH_DAYS[b[3:0]];
    return 8'd31;
  endfunction

  function automatic logic [5:0] blink_for(input logic [1:0] f);
    case (f)
      FIELD_HI:  return 6'b110000;
      FIELD_MID: return 6'b001100;
      default:   return 6'b000011;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - active-low key debouncer emitting a one-cycle press pulse
module key_debounce #(
  parameter int DB_CNT = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic press
);

  localparam int CW = (DB_CNT < 2) ? 1 : $clog2(DB_CNT + 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  // level only flips after DB_CNT consecutive disagreeing samples; a press is the high->low flip
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key_in};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CNT - 1)) begin
        level <= sync[1];
        cnt   <= '0;
        press <= ~sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - key-driven display mode FSM and BCD time/date editor
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int DB_CNT = 500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_mode,
  input  logic        key_sel,
  input  logic        key_inc,
  input  logic [23:0] time_num,
  input  logic [23:0] data_num,
  output logic [1:0]  model,
  output logic        date_time_ch,
  output logic [23:0] adjust_time_num,
  output logic [23:0] adjust_date_num,
  output logic [5:0]  blink_mask
);

  logic       mode_p, sel_p, inc_p;
  state_t     state;
  logic [1:0] field;
  logic [1:0] field_nxt;
  logic       adjusting;
  logic [7:0] mo_inc, mo_inc_days, day_cur_max;

  key_debounce #(.DB_CNT(DB_CNT)) u_db_mode (.clk(clk), .rst_n(rst_n), .key_in(key_mode), .press(mode_p));
  key_debounce #(.DB_CNT(DB_CNT)) u_db_sel  (.clk(clk), .rst_n(rst_n), .key_in(key_sel),  .press(sel_p));
  key_debounce #(.DB_CNT(DB_CNT)) u_db_inc  (.clk(clk), .rst_n(rst_n), .key_in(key_inc),  .press(inc_p));

  always_comb begin
    adjusting   = (state == ADJ_T) || (state == ADJ_D);
    field_nxt   = (field == FIELD_LO) ? FIELD_HI : field - 2'd1;
    mo_inc      = field_inc(adjust_date_num[15:8], MONTH_MIN, MONTH_MAX);
    mo_inc_days = month_days(mo_inc);
    day_cur_max = month_days(adjust_date_num[15:8]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= RUN_T;
      model           <= MODEL_TIME;
      date_time_ch    <= 1'b0;
      adjust_time_num <= TIME_RST;
      adjust_date_num <= DATE_RST;
      field           <= FIELD_HI;
      blink_mask      <= 6'b000000;
    end else if (mode_p) begin
      field <= FIELD_HI;
      unique case (state)
        RUN_T: begin
          state        <= RUN_D;
          model        <= MODEL_DATE;
          date_time_ch <= 1'b1;
          blink_mask   <= 6'b000000;
        end
        RUN_D: begin
          state           <= ADJ_T;
          model           <= MODEL_ADJ;
          date_time_ch    <= 1'b0;
          blink_mask      <= blink_for(FIELD_HI);
          adjust_time_num <= time_num;
        end
        ADJ_T: begin
          state           <= ADJ_D;
          model           <= MODEL_ADJ;
          date_time_ch    <= 1'b1;
          blink_mask      <= blink_for(FIELD_HI);
          adjust_date_num <= data_num;
        end
        ADJ_D: begin
          state        <= RUN_T;
          model        <= MODEL_TIME;
          date_time_ch <= 1'b0;
          blink_mask   <= 6'b000000;
        end
      endcase
    end else if (sel_p && adjusting) begin
      field      <= field_nxt;
      blink_mask <= blink_for(field_nxt);
    end else if (inc_p && state == ADJ_T) begin
      case (field)
        FIELD_HI:  adjust_time_num[23:16] <= field_inc(adjust_time_num[23:16], HOUR_MIN, HOUR_MAX);
        FIELD_MID: adjust_time_num[15:8]  <= field_inc(adjust_time_num[15:8], MS_MIN, MS_MAX);
        default:   adjust_time_num[7:0]   <= field_inc(adjust_time_num[7:0], MS_MIN, MS_MAX);
      endcase
    end else if (inc_p && state == ADJ_D) begin
      case (field)
        FIELD_HI:  adjust_date_num[23:16] <= field_inc(adjust_date_num[23:16], YEAR_MIN, YEAR_MAX);
        FIELD_MID: begin
          adjust_date_num[15:8] <= mo_inc;
          // a day past the new month's end is pulled back to that month's last day
          if (bcd2bin(adjust_date_num[7:0]) > mo_inc_days)
            adjust_date_num[7:0] <= bin2bcd(mo_inc_days);
        end
        default:   adjust_date_num[7:0] <= field_inc(adjust_date_num[7:0], DAY_MIN, day_cur_max);
      endcase
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - scoreboard bench for time_set_ctrl with a calendar reference model
module tb_time_set_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_mode = 1'b1, key_sel = 1'b1, key_inc = 1'b1;
  logic [23:0] time_num = 24'h000000;
  logic [23:0] data_num = 24'h000101;
  logic [1:0]  model;
  logic        date_time_ch;
  logic [23:0] adjust_time_num, adjust_date_num;
  logic [5:0]  blink_mask;

  time_set_ctrl #(.DB_CNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_mode(key_mode), .key_sel(key_sel), .key_inc(key_inc),
    .time_num(time_num), .data_num(data_num), .model(model), .date_time_ch(date_time_ch),
    .adjust_time_num(adjust_time_num), .adjust_date_num(adjust_date_num), .blink_mask(blink_mask)
  );

  always #5 clk = ~clk;

  typedef logic [56:0] snap_t;
  snap_t exp_q[$];
  snap_t last_exp, prev;
  bit    mon_en = 1'b0;
  int    total = 0, bad = 0;

  // reference model: mode index 0..3 = time, date, adjust time, adjust date
  int         s, f;
  logic [7:0] mt[3], md[3];

  function automatic int bval(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit bok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] tob(input int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction

  function automatic int dim(input logic [7:0] mo);
    int tbl[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    int v;
    v = bval(mo);
    if (bok(mo) && v >= 1 && v <= 12) return tbl[v-1];
    return 31;
  endfunction

  function automatic logic [7:0] incf(input logic [7:0] b, input int lo, input int hi);
    int v;
    v = bval(b);
    if (bok(b) && v >= lo && v < hi) return tob(v + 1);
    return tob(lo);
  endfunction

  function automatic snap_t model_snap();
    logic [1:0] m;
    logic       ch;
    logic [5:0] bl;
    m  = (s == 0) ? 2'b00 : (s == 1) ? 2'b01 : 2'b11;
    ch = (s == 1 || s == 3);
    bl = (s < 2) ? 6'b000000 : (f == 2) ? 6'b110000 : (f == 1) ? 6'b001100 : 6'b000011;
    return {m, ch, mt[2], mt[1], mt[0], md[2], md[1], md[0], bl};
  endfunction

  task automatic push_if_changed();
    snap_t sn;
    sn = model_snap();
    if (sn != last_exp) begin
      exp_q.push_back(sn);
      last_exp = sn;
    end
  endtask

  task automatic apply(input bit m, input bit sl, input bit in);
    if (m) begin
      if (s == 1) begin mt[2] = time_num[23:16]; mt[1] = time_num[15:8]; mt[0] = time_num[7:0]; end
      if (s == 2) begin md[2] = data_num[23:16]; md[1] = data_num[15:8]; md[0] = data_num[7:0]; end
      s = (s + 1) % 4;
      f = 2;
    end else if (sl && s >= 2) begin
      f = (f == 0) ? 2 : f - 1;
    end else if (in && s == 2) begin
      mt[f] = incf(mt[f], 0, (f == 2) ? 23 : 59);
    end else if (in && s == 3) begin
      if (f == 2) md[2] = incf(md[2], 0, 99);
      else if (f == 1) begin
        md[1] = incf(md[1], 1, 12);
        if (bval(md[0]) > dim(md[1])) md[0] = tob(dim(md[1]));
      end else md[0] = incf(md[0], 1, dim(md[1]));
    end
    push_if_changed();
  endtask

  task automatic drive(input bit m, input bit sl, input bit in, input int hold);
    @(posedge clk); #1;
    key_mode = ~m; key_sel = ~sl; key_inc = ~in;
    repeat (hold) @(posedge clk);
    #1;
    key_mode = 1'b1; key_sel = 1'b1; key_inc = 1'b1;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic press(input bit m, input bit sl, input bit in);
    apply(m, sl, in);
    drive(m, sl, in, 10);
  endtask

  task automatic check(input string nm, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    snap_t cur, e;
    if (mon_en) begin
      cur = {model, date_time_ch, adjust_time_num, adjust_date_num, blink_mask};
      if (cur !== prev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change got=%h", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            bad++;
            $display("FAIL snapshot got=%h exp=%h", cur, e);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    int op, k, waited;
    repeat (3) @(posedge clk);
    #1;
    check("rst_model", model, 24'h0);
    check("rst_ch", date_time_ch, 24'h0);
    check("rst_time", adjust_time_num, 24'h000000);
    check("rst_date", adjust_date_num, 24'h000101);
    check("rst_blink", blink_mask, 24'h0);

    s = 0; f = 2;
    mt[2] = 8'h00; mt[1] = 8'h00; mt[0] = 8'h00;
    md[2] = 8'h00; md[1] = 8'h01; md[0] = 8'h01;
    last_exp = model_snap();
    prev = last_exp;
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    drive(0, 0, 1, 2);
    drive(1, 0, 0, 2);
    check("glitch_model", model, 24'h0);
    press(1, 0, 0);
    check("one_advance", model, 24'h1);

    time_num = 24'h235649;
    press(1, 0, 0);
    check("load_time", adjust_time_num, 24'h235649);
    check("adj_model", model, 24'h3);
    check("adj_blink", blink_mask, 24'h30);
    press(0, 0, 1);
    check("hour_wrap", adjust_time_num, 24'h005649);
    press(0, 1, 0);
    press(0, 1, 0);
    check("blink_sec", blink_mask, 24'h03);
    for (k = 0; k < 10; k++) press(0, 0, 1);
    check("sec_59", adjust_time_num, 24'h005659);
    press(0, 0, 1);
    check("sec_wrap", adjust_time_num, 24'h005600);

    data_num = 24'h200131;
    press(1, 0, 0);
    press(0, 1, 0);
    press(0, 0, 1);
    check("day_clamp", adjust_date_num, 24'h200228);
    for (k = 0; k < 10; k++) press(0, 0, 1);
    check("month_12", adjust_date_num, 24'h201228);
    press(0, 0, 1);
    check("month_wrap", adjust_date_num, 24'h200128);

    press(1, 0, 0);
    press(1, 0, 0);
    time_num = 24'h3A5649;
    press(1, 0, 0);
    press(0, 0, 1);
    check("bad_bcd", adjust_time_num, 24'h005649);
    press(1, 0, 1);
    check("mode_inc_time", adjust_time_num, 24'h005649);
    check("mode_inc_ch", date_time_ch, 24'h1);

    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 6);
      time_num = {tob($urandom_range(0, 23)), tob($urandom_range(0, 59)), tob($urandom_range(0, 59))};
      data_num = {tob($urandom_range(0, 99)), tob($urandom_range(1, 12)), tob($urandom_range(1, 31))};
      case (op)
        0:       press(1, 0, 0);
        1:       press(0, 1, 0);
        2, 3:    press(0, 0, 1);
        4:       press(1, 1, 0);
        5:       press(0, 1, 1);
        default: drive(op[0], op[1], 1'b1, $urandom_range(1, 3));
      endcase
    end

    k = 0;
    while (s != 3 && k < 4) begin
      press(1, 0, 0);
      k++;
    end
    s = 0; f = 2;
    mt[2] = 8'h00; mt[1] = 8'h00; mt[0] = 8'h00;
    md[2] = 8'h00; md[1] = 8'h01; md[0] = 8'h01;
    push_if_changed();
    @(posedge clk); #1;
    key_mode = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_model", model, 24'h0);
    check("rst_mid_date", adjust_date_num, 24'h000101);
    check("rst_mid_blink", blink_mask, 24'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    key_mode = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_model", model, 24'h0);

    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(posedge clk);
      waited++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_expect got=%0d exp=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
